// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its counter.
package bcd_stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   N_DIGITS = 3;

  // Next value of a single BCD digit, wrapping 9 back to 0.
  function automatic bcd_t bcd_next(input bcd_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_cnt3_en.sv
// Three-digit BCD up-counter with enable, synchronous clear and saturation at 999.
module bcd_cnt3_en
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic ck,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output bcd_t d2,
  output bcd_t d1,
  output bcd_t d0,
  output logic all_nines
);

  bcd_t [N_DIGITS-1:0] r_dig;
  logic [N_DIGITS-1:0] w_nine;
  logic [N_DIGITS-1:0] w_carry;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nine
      assign w_nine[gi] = (r_dig[gi] == BCD_MAX);
    end
  endgenerate

  // Ripple carry; an increment at 999 is swallowed so the count saturates.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = en && !(&w_nine);
    for (int i = 1; i < N_DIGITS; i++) begin
      w_carry[i] = w_carry[i-1] && w_nine[i-1];
    end
  end

  always_ff @(posedge ck) begin
    if (rs || clr) begin
      r_dig <= '0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (w_carry[i]) begin
          r_dig[i] <= bcd_next(r_dig[i]);
        end
      end
    end
  end

  assign d2        = r_dig[2];
  assign d1        = r_dig[1];
  assign d0        = r_dig[0];
  assign all_nines = &w_nine;

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap FSM, tick prescaler, lap capture and display mux
// around a three-digit BCD counter.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 10
)
(
  input  logic ck,
  input  logic rs,
  input  logic tick,
  input  logic btn_ss,
  input  logic btn_lc,
  output bcd_t bcd2,
  output bcd_t bcd1,
  output bcd_t bcd0,
  output logic running,
  output logic lap_held,
  output logic ovf
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_pre;
  bcd_t [N_DIGITS-1:0] r_lap;
  logic                r_ovf;

  bcd_t [N_DIGITS-1:0] w_cnt;
  logic                w_all_nines;
  logic                w_active;
  logic                w_inc;
  logic                w_ovf_hit;
  logic                w_capture;
  logic                w_clear;

  // Ticks are only seen in RUN/LAP, so a tick on the entry edge into RUN is dropped
  // while a tick on the RUN->STOP edge still counts.
  assign w_active  = (r_state == ST_RUN) || (r_state == ST_LAP);
  assign w_inc     = w_active && tick && (r_pre == PRE_LAST);
  assign w_ovf_hit = w_inc && w_all_nines;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (btn_ss) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (btn_ss) begin
          w_state_next = ST_STOP;
        end else if (btn_lc) begin
          w_state_next = ST_LAP;
          w_capture    = 1'b1;
        end
      end
      ST_LAP: begin
        if (btn_ss)      w_state_next = ST_STOP;
        else if (btn_lc) w_state_next = ST_RUN;
      end
      ST_STOP: begin
        if (btn_ss) begin
          w_state_next = ST_RUN;
        end else if (btn_lc) begin
          w_state_next = ST_IDLE;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_ovf_hit) w_state_next = ST_STOP;
  end

  always_ff @(posedge ck) begin
    if (rs) r_state <= ST_IDLE;
    else    r_state <= w_state_next;
  end

  always_ff @(posedge ck) begin
    if (rs || w_clear) begin
      r_pre <= '0;
    end else if (w_active && tick) begin
      r_pre <= (r_pre == PRE_LAST) ? 8'd0 : r_pre + 8'd1;
    end
  end

  // Capture reads the counter before this edge's increment lands.
  always_ff @(posedge ck) begin
    if (rs || w_clear) begin
      r_lap <= '0;
    end else if (w_capture) begin
      r_lap <= w_cnt;
    end
  end

  always_ff @(posedge ck) begin
    if (rs || w_clear) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_hit) begin
      r_ovf <= 1'b1;
    end
  end

  bcd_cnt3_en u_cnt (
    .ck        (ck),
    .rs        (rs),
    .en        (w_inc),
    .clr       (w_clear),
    .d2        (w_cnt[2]),
    .d1        (w_cnt[1]),
    .d0        (w_cnt[0]),
    .all_nines (w_all_nines)
  );

  assign bcd2     = (r_state == ST_LAP) ? r_lap[2] : w_cnt[2];
  assign bcd1     = (r_state == ST_LAP) ? r_lap[1] : w_cnt[1];
  assign bcd0     = (r_state == ST_LAP) ? r_lap[0] : w_cnt[0];
  assign running  = w_active;
  assign lap_held = (r_state == ST_LAP);
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl: directed scenarios plus a randomized run
// against a behavioural stopwatch model.
module tb_bcd_stopwatch_ctrl;

  localparam int P = 2;

  logic       ck = 1'b0;
  logic       rs = 1'b0;
  logic       tick = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lc = 1'b0;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       running, lap_held, ovf;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: integer count 0..999, mode as a small code of its own.
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;
  int m_mode, m_cnt, m_pre, m_lap;
  bit m_ovf;

  bcd_stopwatch_ctrl #(.PRESCALE(P)) dut (
    .ck       (ck),
    .rs       (rs),
    .tick     (tick),
    .btn_ss   (btn_ss),
    .btn_lc   (btn_lc),
    .bcd2     (bcd2),
    .bcd1     (bcd1),
    .bcd0     (bcd0),
    .running  (running),
    .lap_held (lap_held),
    .ovf      (ovf)
  );

  always #5 ck = ~ck;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [14:0] obs();
    return {bcd2, bcd1, bcd0, running, lap_held, ovf};
  endfunction

  function automatic logic [14:0] model_obs();
    int shown;
    shown = (m_mode == M_LAP) ? m_lap : m_cnt;
    return {to_bcd(shown), 1'(m_mode == M_RUN || m_mode == M_LAP), 1'(m_mode == M_LAP), m_ovf};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit s, input bit l);
    bit counting, bump;
    if (r) begin
      m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_lap = 0; m_ovf = 0;
      return;
    end
    counting = (m_mode == M_RUN || m_mode == M_LAP);
    bump = 0;
    if (counting && t) begin
      m_pre = m_pre + 1;
      if (m_pre == P) begin
        m_pre = 0;
        bump = 1;
      end
    end
    if (m_mode == M_RUN && l && !s) m_lap = m_cnt;
    case (m_mode)
      M_IDLE: if (s) m_mode = M_RUN;
      M_RUN:  if (s) m_mode = M_STOP; else if (l) m_mode = M_LAP;
      M_LAP:  if (s) m_mode = M_STOP; else if (l) m_mode = M_RUN;
      default: begin
        if (s) m_mode = M_RUN;
        else if (l) begin
          m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_lap = 0; m_ovf = 0;
        end
      end
    endcase
    if (bump) begin
      if (m_cnt == 999) begin
        m_ovf  = 1;
        m_mode = M_STOP;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit s, input bit l);
    rs = r; tick = t; btn_ss = s; btn_lc = l;
    @(posedge ck);
    model_step(r, t, s, l);
    #1;
    rs = 0; tick = 0; btn_ss = 0; btn_lc = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_vec++;
    if (obs() !== 15'h0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs(), 15'h0);
    end
    cyc(0, 1, 0, 1);
    n_vec++;
    if (obs() !== 15'h0) begin
      n_err++;
      $display("FAIL idle_ignores_tick_lc: got %h expected %h", obs(), 15'h0);
    end
    $display("test_reset done");
  endtask

  task automatic test_count();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(20);
    n_vec++;
    if (obs() !== {12'h010, 3'b100}) begin
      n_err++;
      $display("FAIL count_20_ticks: got %h expected %h", obs(), {12'h010, 3'b100});
    end
    $display("test_count done");
  endtask

  task automatic test_start_stop_tick();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    ticks(1);
    n_vec++;
    if (obs() !== {12'h000, 3'b100}) begin
      n_err++;
      $display("FAIL start_tick_dropped: got %h expected %h", obs(), {12'h000, 3'b100});
    end
    cyc(0, 1, 1, 0);
    n_vec++;
    if (obs() !== {12'h001, 3'b000}) begin
      n_err++;
      $display("FAIL stop_tick_counted: got %h expected %h", obs(), {12'h001, 3'b000});
    end
    $display("test_start_stop_tick done");
  endtask

  task automatic test_lap();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(10);
    cyc(0, 0, 0, 1);
    n_vec++;
    if (obs() !== {12'h005, 3'b110}) begin
      n_err++;
      $display("FAIL lap_enter: got %h expected %h", obs(), {12'h005, 3'b110});
    end
    ticks(6);
    n_vec++;
    if (obs() !== {12'h005, 3'b110}) begin
      n_err++;
      $display("FAIL lap_hold: got %h expected %h", obs(), {12'h005, 3'b110});
    end
    cyc(0, 0, 0, 1);
    n_vec++;
    if (obs() !== {12'h008, 3'b100}) begin
      n_err++;
      $display("FAIL lap_release: got %h expected %h", obs(), {12'h008, 3'b100});
    end
    $display("test_lap done");
  endtask

  task automatic test_stop_resume();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(246);
    cyc(0, 0, 1, 0);
    n_vec++;
    if (obs() !== {12'h123, 3'b000}) begin
      n_err++;
      $display("FAIL stop_123: got %h expected %h", obs(), {12'h123, 3'b000});
    end
    cyc(0, 0, 1, 0);
    ticks(2);
    n_vec++;
    if (obs() !== {12'h124, 3'b100}) begin
      n_err++;
      $display("FAIL resume_124: got %h expected %h", obs(), {12'h124, 3'b100});
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    n_vec++;
    if (obs() !== {12'h000, 3'b000}) begin
      n_err++;
      $display("FAIL clear_to_idle: got %h expected %h", obs(), {12'h000, 3'b000});
    end
    cyc(0, 1, 0, 1);
    ticks(3);
    n_vec++;
    if (obs() !== {12'h000, 3'b000}) begin
      n_err++;
      $display("FAIL cleared_is_idle: got %h expected %h", obs(), {12'h000, 3'b000});
    end
    $display("test_stop_resume done");
  endtask

  task automatic test_overflow();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(1999);
    n_vec++;
    if (obs() !== {12'h999, 3'b100}) begin
      n_err++;
      $display("FAIL reach_999: got %h expected %h", obs(), {12'h999, 3'b100});
    end
    ticks(1);
    n_vec++;
    if (obs() !== {12'h999, 3'b001}) begin
      n_err++;
      $display("FAIL overflow_hit: got %h expected %h", obs(), {12'h999, 3'b001});
    end
    cyc(0, 0, 1, 0);
    n_vec++;
    if (obs() !== {12'h999, 3'b101}) begin
      n_err++;
      $display("FAIL ovf_sticky_run: got %h expected %h", obs(), {12'h999, 3'b101});
    end
    cyc(0, 0, 1, 0);
    n_vec++;
    if (obs() !== {12'h999, 3'b001}) begin
      n_err++;
      $display("FAIL ovf_sticky_stop: got %h expected %h", obs(), {12'h999, 3'b001});
    end
    cyc(0, 0, 0, 1);
    n_vec++;
    if (obs() !== {12'h000, 3'b000}) begin
      n_err++;
      $display("FAIL ovf_cleared: got %h expected %h", obs(), {12'h000, 3'b000});
    end
    $display("test_overflow done");
  endtask

  task automatic test_simultaneous();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(3);
    cyc(0, 0, 1, 1);
    n_vec++;
    if (obs() !== {12'h001, 3'b000}) begin
      n_err++;
      $display("FAIL both_btn_run: got %h expected %h", obs(), {12'h001, 3'b000});
    end
    cyc(0, 0, 1, 1);
    n_vec++;
    if (obs() !== {12'h001, 3'b100}) begin
      n_err++;
      $display("FAIL both_btn_stop: got %h expected %h", obs(), {12'h001, 3'b100});
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid_lap();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    ticks(94);
    cyc(0, 0, 0, 1);
    n_vec++;
    if (obs() !== {12'h047, 3'b110}) begin
      n_err++;
      $display("FAIL lap_047: got %h expected %h", obs(), {12'h047, 3'b110});
    end
    cyc(1, 1, 1, 1);
    n_vec++;
    if (obs() !== 15'h0) begin
      n_err++;
      $display("FAIL reset_mid_lap: got %h expected %h", obs(), 15'h0);
    end
    $display("test_reset_mid_lap done");
  endtask

  task automatic test_random();
    bit r, t, s, l;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 14) == 0);
      cyc(r, t, s, l);
      n_vec++;
      if (obs() !== model_obs()) begin
        n_err++;
        $display("FAIL random_cyc%0d: got %h expected %h (rs=%b tick=%b ss=%b lc=%b)",
                 i, obs(), model_obs(), r, t, s, l);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_count();
    test_start_stop_tick();
    test_lap();
    test_stop_resume();
    test_overflow();
    test_simultaneous();
    test_reset_mid_lap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
